// File: rtl/tile_seq_pkg.sv
// Shared types and constants for the tiled GEMM sequencer: FSM states,
// CSR offsets, the unmapped-read pattern and the tile address helper.
package tile_seq_pkg;

    typedef enum logic [3:0] {
        IDLE,
        PRELOAD_B,
        SWITCH,
        COMPUTE,
        DRAIN,
        WB_START,
        WB_WAIT,
        ADVANCE,
        DONE
    } state_t;

    localparam logic [31:0] UNMAPPED = 32'hDEAD_BEEF;

    localparam int unsigned CSR_CTRL     = 32'h00;
    localparam int unsigned CSR_STATUS   = 32'h04;
    localparam int unsigned CSR_M        = 32'h10;
    localparam int unsigned CSR_K        = 32'h14;
    localparam int unsigned CSR_N        = 32'h18;
    localparam int unsigned CSR_A        = 32'h20;
    localparam int unsigned CSR_B        = 32'h24;
    localparam int unsigned CSR_C        = 32'h28;
    localparam int unsigned CSR_D        = 32'h2C;
    localparam int unsigned CSR_DDR      = 32'h30;
    localparam int unsigned CSR_PROGRESS = 32'h34;
    localparam int unsigned CSR_PERF     = 32'h40;

    // Linear tile index (outer*count + inner) scaled by the tile width.
    function automatic logic [31:0] tile_offset(input logic [15:0] outer,
                                                input logic [15:0] count,
                                                input logic [15:0] inner,
                                                input int unsigned lw);
        return ((32'(outer) * 32'(count)) + 32'(inner)) << lw;
    endfunction

endpackage

// File: rtl/tiled_gemm_sequencer_if.sv
// CSR, buffer, core and writeback signals of the tiled GEMM sequencer.
// slave = sequencer side, master = host/environment side.
interface tiled_gemm_sequencer_if #(
    parameter int W              = 16,
    parameter int ADDR_WIDTH     = 10,
    parameter int CSR_ADDR_WIDTH = 8
);
    logic [CSR_ADDR_WIDTH-1:0] csr_addr;
    logic                      csr_wr_en;
    logic [31:0]               csr_wr_data;
    logic [31:0]               csr_rd_data;
    logic                      core_wb_valid;
    logic                      b_load;
    logic [ADDR_WIDTH-1:0]     b_addr;
    logic [$clog2(W)-1:0]      b_index;
    logic                      a_valid;
    logic [ADDR_WIDTH-1:0]     a_addr;
    logic                      a_switch;
    logic                      c_rd_en;
    logic [ADDR_WIDTH-1:0]     c_addr;
    logic                      acc_sel;
    logic                      d_wr_en;
    logic [ADDR_WIDTH-1:0]     d_addr;
    logic [W-1:0]              row_mask;
    logic [W-1:0]              col_mask;
    logic                      axi_start;
    logic [ADDR_WIDTH-1:0]     axi_src_addr;
    logic [31:0]               axi_dest_addr;
    logic [15:0]               axi_length;
    logic                      axi_done;
    logic                      irq;

    modport slave (
        input  csr_addr, csr_wr_en, csr_wr_data, core_wb_valid, axi_done,
        output csr_rd_data, b_load, b_addr, b_index, a_valid, a_addr, a_switch,
               c_rd_en, c_addr, acc_sel, d_wr_en, d_addr, row_mask, col_mask,
               axi_start, axi_src_addr, axi_dest_addr, axi_length, irq
    );

    modport master (
        output csr_addr, csr_wr_en, csr_wr_data, core_wb_valid, axi_done,
        input  csr_rd_data, b_load, b_addr, b_index, a_valid, a_addr, a_switch,
               c_rd_en, c_addr, acc_sel, d_wr_en, d_addr, row_mask, col_mask,
               axi_start, axi_src_addr, axi_dest_addr, axi_length, irq
    );
endinterface

// File: rtl/tiled_gemm_sequencer_tile_iter.sv
// (mt, nt, kt) tile loop counters with tile counts and edge-tile remainders.
// Loop order: mt outer, nt middle, kt inner.
module tile_iter #(
    parameter int W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 step_k,
    input  logic                 step_tile,
    input  logic [15:0]          m_size,
    input  logic [15:0]          k_size,
    input  logic [15:0]          n_size,
    output logic [15:0]          mt,
    output logic [15:0]          nt,
    output logic [15:0]          kt,
    output logic [15:0]          n_tiles,
    output logic [15:0]          k_tiles,
    output logic [$clog2(W):0]   m_rem,
    output logic [$clog2(W):0]   k_rem,
    output logic [$clog2(W):0]   n_rem,
    output logic                 last_k,
    output logic                 last_tile
);
    localparam int LW = $clog2(W);

    logic [15:0] m_tiles;

    function automatic logic [15:0] tiles(input logic [15:0] total);
        logic [16:0] sum;
        sum = 17'(total) + 17'(W - 1);
        return 16'(sum >> LW);
    endfunction

    // min(W, total - t*W), clamped at zero
    function automatic logic [LW:0] rem(input logic [15:0] total, input logic [15:0] t);
        logic [31:0] used;
        logic [31:0] left;
        used = 32'(t) << LW;
        left = 32'(total) - used;
        if (32'(total) <= used) return '0;
        if (left >= 32'(W)) return (LW+1)'(W);
        return left[LW:0];
    endfunction

    assign m_tiles   = tiles(m_size);
    assign n_tiles   = tiles(n_size);
    assign k_tiles   = tiles(k_size);
    assign m_rem     = rem(m_size, mt);
    assign n_rem     = rem(n_size, nt);
    assign k_rem     = rem(k_size, kt);
    assign last_k    = (kt == k_tiles - 16'd1);
    assign last_tile = (mt == m_tiles - 16'd1) && (nt == n_tiles - 16'd1);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            mt <= '0;
            nt <= '0;
            kt <= '0;
        end else if (step_k) begin
            kt <= kt + 16'd1;
        end else if (step_tile) begin
            kt <= '0;
            if (nt == n_tiles - 16'd1) begin
                nt <= '0;
                mt <= mt + 16'd1;
            end else begin
                nt <= nt + 16'd1;
            end
        end
    end

endmodule

// File: rtl/tiled_gemm_sequencer.sv
// Tiled GEMM sequencer: CSR block, tile FSM and buffer/writeback address generation.
// Optional busy-cycle counter at CSR 0x40 when TILE_PERF_CNT_EN is defined.
module tiled_gemm_sequencer
    import tile_seq_pkg::*;
#(
    parameter int W              = 16,
    parameter int ADDR_WIDTH     = 10,
    parameter int CSR_ADDR_WIDTH = 8
) (
    input logic                   clk,
    input logic                   rst,
    tiled_gemm_sequencer_if.slave bus
);
    localparam int LW = $clog2(W);

    state_t                state, state_next;
    logic [15:0]           m_size, k_size, n_size;
    logic [ADDR_WIDTH-1:0] a_base, b_base, c_base, d_base;
    logic [31:0]           ddr_base;
    logic                  err, done;
    logic [LW-1:0]         idx;
    logic [LW:0]           row;

    logic [15:0]           mt, nt, kt, n_tiles, k_tiles;
    logic [LW:0]           m_rem, k_rem, n_rem;
    logic                  last_k, last_tile;
    logic                  accept, zero_start, step_k, step_tile;
    logic                  start_req, size_ok, idx_last, wr_row;
    logic [31:0]           csr_sel, tile_lin;
    logic [ADDR_WIDTH-1:0] d_tile;

    assign csr_sel   = 32'(bus.csr_addr);
    assign start_req = bus.csr_wr_en && (csr_sel == CSR_CTRL) && bus.csr_wr_data[0];
    assign size_ok   = (m_size != '0) && (k_size != '0) && (n_size != '0);
    assign idx_last  = (idx == LW'(W - 1));
    assign wr_row    = ((state == COMPUTE) || (state == DRAIN)) && bus.core_wb_valid && (row < m_rem);
    assign tile_lin  = tile_offset(mt, n_tiles, nt, LW);
    assign d_tile    = ADDR_WIDTH'(32'(d_base) + tile_lin);

    tile_iter #(.W(W)) u_iter (
        .clk       (clk),
        .rst       (rst),
        .clear     (accept),
        .step_k    (step_k),
        .step_tile (step_tile),
        .m_size    (m_size),
        .k_size    (k_size),
        .n_size    (n_size),
        .mt        (mt),
        .nt        (nt),
        .kt        (kt),
        .n_tiles   (n_tiles),
        .k_tiles   (k_tiles),
        .m_rem     (m_rem),
        .k_rem     (k_rem),
        .n_rem     (n_rem),
        .last_k    (last_k),
        .last_tile (last_tile)
    );

    function automatic logic [W-1:0] mask_of(input logic [LW:0] rem_cnt);
        logic [W-1:0] m;
        for (int i = 0; i < W; i++) m[i] = (32'(i) < 32'(rem_cnt));
        return m;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        zero_start = 1'b0;
        step_k     = 1'b0;
        step_tile  = 1'b0;
        unique case (state)
            IDLE: begin
                if (start_req) begin
                    if (size_ok) begin
                        accept     = 1'b1;
                        state_next = PRELOAD_B;
                    end else begin
                        zero_start = 1'b1;
                    end
                end
            end
            PRELOAD_B: if (idx_last) state_next = SWITCH;
            SWITCH:    state_next = COMPUTE;
            COMPUTE:   if (idx_last) state_next = DRAIN;
            DRAIN: begin
                if (row == m_rem) begin
                    if (last_k) begin
                        state_next = WB_START;
                    end else begin
                        step_k     = 1'b1;
                        state_next = PRELOAD_B;
                    end
                end
            end
            WB_START: state_next = WB_WAIT;
            WB_WAIT:  if (bus.axi_done) state_next = ADVANCE;
            ADVANCE: begin
                if (last_tile) begin
                    state_next = DONE;
                end else begin
                    step_tile  = 1'b1;
                    state_next = PRELOAD_B;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // idx sweeps 0..W-1 within PRELOAD_B and COMPUTE; row counts result rows per kt pass
    always_ff @(posedge clk) begin
        if (rst || (state_next != state)) idx <= '0;
        else if ((state == PRELOAD_B) || (state == COMPUTE)) idx <= idx + LW'(1);

        if (rst || ((state_next == PRELOAD_B) && (state != PRELOAD_B))) row <= '0;
        else if (wr_row) row <= row + (LW+1)'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_size   <= '0;
            k_size   <= '0;
            n_size   <= '0;
            a_base   <= '0;
            b_base   <= '0;
            c_base   <= '0;
            d_base   <= '0;
            ddr_base <= '0;
            err      <= 1'b0;
            done     <= 1'b0;
        end else begin
            if (bus.csr_wr_en) begin
                case (csr_sel)
                    CSR_M:   m_size   <= bus.csr_wr_data[15:0];
                    CSR_K:   k_size   <= bus.csr_wr_data[15:0];
                    CSR_N:   n_size   <= bus.csr_wr_data[15:0];
                    CSR_A:   a_base   <= bus.csr_wr_data[ADDR_WIDTH-1:0];
                    CSR_B:   b_base   <= bus.csr_wr_data[ADDR_WIDTH-1:0];
                    CSR_C:   c_base   <= bus.csr_wr_data[ADDR_WIDTH-1:0];
                    CSR_D:   d_base   <= bus.csr_wr_data[ADDR_WIDTH-1:0];
                    CSR_DDR: ddr_base <= bus.csr_wr_data;
                    default: ;
                endcase
            end
            if (accept) begin
                err  <= 1'b0;
                done <= 1'b0;
            end else if (zero_start) begin
                err <= 1'b1;
            end
            if ((state == ADVANCE) && (state_next == DONE)) done <= 1'b1;
        end
    end

`ifdef TILE_PERF_CNT_EN
    logic [31:0] perf_cnt;

    always_ff @(posedge clk) begin
        if (rst || accept)   perf_cnt <= '0;
        else if (state != IDLE) perf_cnt <= perf_cnt + 32'd1;
    end
`endif

    always_comb begin
        case (csr_sel)
            CSR_CTRL:     bus.csr_rd_data = '0;
            CSR_STATUS:   bus.csr_rd_data = {29'd0, err, done, state != IDLE};
            CSR_M:        bus.csr_rd_data = {16'd0, m_size};
            CSR_K:        bus.csr_rd_data = {16'd0, k_size};
            CSR_N:        bus.csr_rd_data = {16'd0, n_size};
            CSR_A:        bus.csr_rd_data = 32'(a_base);
            CSR_B:        bus.csr_rd_data = 32'(b_base);
            CSR_C:        bus.csr_rd_data = 32'(c_base);
            CSR_D:        bus.csr_rd_data = 32'(d_base);
            CSR_DDR:      bus.csr_rd_data = ddr_base;
            CSR_PROGRESS: bus.csr_rd_data = {2'b00, mt[9:0], nt[9:0], kt[9:0]};
`ifdef TILE_PERF_CNT_EN
            CSR_PERF:     bus.csr_rd_data = perf_cnt;
`endif
            default:      bus.csr_rd_data = UNMAPPED;
        endcase
    end

    // Address outputs are held at zero outside the state that owns them
    always_comb begin
        bus.b_load        = 1'b0;
        bus.b_addr        = '0;
        bus.b_index       = '0;
        bus.a_valid       = 1'b0;
        bus.a_addr        = '0;
        bus.a_switch      = 1'b0;
        bus.c_rd_en       = 1'b0;
        bus.c_addr        = '0;
        bus.d_wr_en       = wr_row;
        bus.d_addr        = '0;
        bus.axi_start     = 1'b0;
        bus.axi_src_addr  = '0;
        bus.axi_dest_addr = '0;
        bus.axi_length    = '0;
        bus.irq           = 1'b0;
        bus.acc_sel       = (kt != '0);
        bus.row_mask      = mask_of(k_rem);
        bus.col_mask      = mask_of(n_rem);
        unique case (state)
            PRELOAD_B: begin
                bus.b_load  = ({1'b0, idx} < k_rem);
                bus.b_addr  = ADDR_WIDTH'(32'(b_base) + tile_offset(kt, n_tiles, nt, LW) + 32'(idx));
                bus.b_index = idx;
            end
            SWITCH: bus.a_switch = 1'b1;
            COMPUTE: begin
                bus.a_valid = ({1'b0, idx} < m_rem);
                bus.c_rd_en = ({1'b0, idx} < m_rem);
                bus.a_addr  = ADDR_WIDTH'(32'(a_base) + tile_offset(mt, k_tiles, kt, LW) + 32'(idx));
                bus.c_addr  = ADDR_WIDTH'(32'(bus.acc_sel ? d_base : c_base) + tile_lin + 32'(idx));
                bus.d_addr  = d_tile + ADDR_WIDTH'(row);
            end
            DRAIN: bus.d_addr = d_tile + ADDR_WIDTH'(row);
            WB_START: begin
                bus.axi_start     = 1'b1;
                bus.axi_src_addr  = d_tile;
                bus.axi_dest_addr = ddr_base + (tile_lin << LW);
                bus.axi_length    = 16'(m_rem) * 16'(n_rem);
            end
            DONE:    bus.irq = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_tiled_gemm_sequencer.sv
// Directed bench for tiled_gemm_sequencer at W=4: CSR vector table plus
// hand-computed whole-run sequences (single tile, K split, edge tiles, errors, reset).
`timescale 1ns/1ps
module tb_tiled_gemm_sequencer;
    localparam int W  = 4;
    localparam int AW = 10;
    localparam int CW = 8;

    localparam logic [31:0] A_BASE = 32'h100;
    localparam logic [31:0] B_BASE = 32'h200;
    localparam logic [31:0] C_BASE = 32'h300;
    localparam logic [31:0] D_BASE = 32'h380;
    localparam logic [31:0] DDR    = 32'h1000_0000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    tiled_gemm_sequencer_if #(.W(W), .ADDR_WIDTH(AW), .CSR_ADDR_WIDTH(CW)) bus ();

    tiled_gemm_sequencer #(.W(W), .ADDR_WIDTH(AW), .CSR_ADDR_WIDTH(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [7:0]  addr;
        logic        wr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } csr_vec_t;

    csr_vec_t vecs[14];

    int          n_pass, n_pre, n_wb, irq_cnt, bload_cnt, dwr_cnt, acc_cnt;
    logic        busy0, got_irq;
    logic [31:0] p_aval[8], p_acc[8], p_a0[8], p_c0[8], p_rm[8], p_cm[8];
    logic [31:0] pre_b0[8], pre_cnt[8];
    logic [31:0] wb_len[4], wb_dest[4], wb_src[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic csr_write(input logic [7:0] addr, input logic [31:0] data);
        bus.csr_addr    = addr;
        bus.csr_wr_data = data;
        bus.csr_wr_en   = 1'b1;
        @(posedge clk);
        #1;
        bus.csr_wr_en   = 1'b0;
        bus.csr_addr    = 8'h04;
    endtask

    task automatic csr_read(input logic [7:0] addr, output logic [31:0] data);
        bus.csr_addr = addr;
        #1;
        data = bus.csr_rd_data;
        bus.csr_addr = 8'h04;
    endtask

    task automatic setup(input logic [15:0] m, input logic [15:0] k, input logic [15:0] n);
        csr_write(8'h10, 32'(m));
        csr_write(8'h14, 32'(k));
        csr_write(8'h18, 32'(n));
        csr_write(8'h20, A_BASE);
        csr_write(8'h24, B_BASE);
        csr_write(8'h28, C_BASE);
        csr_write(8'h2C, D_BASE);
        csr_write(8'h30, DDR);
    endtask

    // Starts a run and records per-pass / per-writeback observations until irq
    task automatic run_gemm();
        logic prev_sw, prev_bl, prev_ax;
        int   tail;
        n_pass = 0; n_pre = 0; n_wb = 0; irq_cnt = 0; bload_cnt = 0; dwr_cnt = 0; acc_cnt = 0;
        got_irq = 1'b0; busy0 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            p_aval[i] = 0; pre_cnt[i] = 0;
        end
        prev_sw = 1'b0; prev_bl = 1'b0; prev_ax = 1'b0; tail = -1;
        bus.core_wb_valid = 1'b1;
        bus.axi_done      = 1'b0;
        csr_write(8'h00, 32'h1);
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            bus.axi_done = prev_ax;
            if (cyc == 0) busy0 = bus.csr_rd_data[0];
            if (prev_sw) begin
                if (n_pass < 8) begin
                    p_acc[n_pass] = 32'(bus.acc_sel);
                    p_a0[n_pass]  = 32'(bus.a_addr);
                    p_c0[n_pass]  = 32'(bus.c_addr);
                    p_rm[n_pass]  = 32'(bus.row_mask);
                    p_cm[n_pass]  = 32'(bus.col_mask);
                end
                n_pass++;
            end
            if (bus.a_valid && n_pass > 0 && n_pass <= 8) p_aval[n_pass-1]++;
            if (bus.b_load) begin
                bload_cnt++;
                if (!prev_bl && n_pre < 8) begin
                    pre_b0[n_pre] = 32'(bus.b_addr);
                    n_pre++;
                end
                if (n_pre > 0) pre_cnt[n_pre-1]++;
            end
            if (bus.acc_sel) acc_cnt++;
            if (bus.d_wr_en) dwr_cnt++;
            if (bus.axi_start && n_wb < 4) begin
                wb_len[n_wb]  = 32'(bus.axi_length);
                wb_dest[n_wb] = bus.axi_dest_addr;
                wb_src[n_wb]  = 32'(bus.axi_src_addr);
                n_wb++;
            end
            if (bus.irq) begin
                irq_cnt++;
                got_irq = 1'b1;
                if (tail < 0) tail = 2;
            end
            prev_sw = bus.a_switch;
            prev_bl = bus.b_load;
            prev_ax = bus.axi_start;
            if (tail == 0) break;
            if (tail > 0) tail--;
        end
        bus.core_wb_valid = 1'b0;
        bus.axi_done      = 1'b0;
        check("run_completes", 32'(got_irq), 32'h1);
    endtask

    initial begin
        logic [31:0] rd;
        logic        seen;

        vecs[0]  = '{8'h10, 1'b1, 32'hFFFF_1234, 32'h1234};
        vecs[1]  = '{8'h14, 1'b1, 32'h0000_0005, 32'h5};
        vecs[2]  = '{8'h18, 1'b1, 32'hABCD_0007, 32'h7};
        vecs[3]  = '{8'h20, 1'b1, 32'hFFFF_F123, 32'h123};
        vecs[4]  = '{8'h24, 1'b1, 32'h0000_0ABC, 32'h2BC};
        vecs[5]  = '{8'h28, 1'b1, 32'h0000_0300, 32'h300};
        vecs[6]  = '{8'h2C, 1'b1, 32'h0000_0380, 32'h380};
        vecs[7]  = '{8'h30, 1'b1, 32'h8765_4321, 32'h8765_4321};
        vecs[8]  = '{8'h34, 1'b1, 32'hFFFF_FFFF, 32'h0};
        vecs[9]  = '{8'h04, 1'b0, 32'h0, 32'h0};
        vecs[10] = '{8'h08, 1'b0, 32'h0, 32'hDEAD_BEEF};
        vecs[11] = '{8'h3C, 1'b0, 32'h0, 32'hDEAD_BEEF};
`ifdef TILE_PERF_CNT_EN
        vecs[12] = '{8'h40, 1'b0, 32'h0, 32'h0};
`else
        vecs[12] = '{8'h40, 1'b0, 32'h0, 32'hDEAD_BEEF};
`endif
        vecs[13] = '{8'hFC, 1'b0, 32'h0, 32'hDEAD_BEEF};

        rst = 1'b1;
        bus.csr_addr = 8'h04; bus.csr_wr_en = 1'b0; bus.csr_wr_data = '0;
        bus.core_wb_valid = 1'b0; bus.axi_done = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_status", bus.csr_rd_data, 32'h0);
        check("rst_masks", {bus.row_mask, bus.col_mask}, 32'h0);
        check("rst_outs", 32'({bus.b_load, bus.a_valid, bus.irq, bus.axi_start, bus.axi_length}), 32'h0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 14; i++) begin
            if (vecs[i].wr) csr_write(vecs[i].addr, vecs[i].wdata);
            csr_read(vecs[i].addr, rd);
            check($sformatf("csr_%0h", vecs[i].addr), rd, vecs[i].exp);
            @(negedge clk);
        end

        // single tile
        setup(16'd4, 16'd4, 16'd4);
        run_gemm();
        check("s1_busy", 32'(busy0), 32'h1);
        check("s1_passes", 32'(n_pass), 32'h1);
        check("s1_acc_cycles", 32'(acc_cnt), 32'h0);
        check("s1_bload", 32'(bload_cnt), 32'h4);
        check("s1_aval", p_aval[0], 32'h4);
        check("s1_dwr", 32'(dwr_cnt), 32'h4);
        check("s1_len", wb_len[0], 32'd16);
        check("s1_src", wb_src[0], D_BASE);
        check("s1_dest", wb_dest[0], DDR);
        check("s1_irq", 32'(irq_cnt), 32'h1);
        csr_read(8'h04, rd);
        check("s1_status", rd, 32'h2);

        // K split into two passes
        @(negedge clk);
        setup(16'd4, 16'd8, 16'd4);
        run_gemm();
        check("s2_passes", 32'(n_pass), 32'h2);
        check("s2_acc0", p_acc[0], 32'h0);
        check("s2_acc1", p_acc[1], 32'h1);
        check("s2_a0", p_a0[0], A_BASE);
        check("s2_a1", p_a0[1], A_BASE + 32'h4);
        check("s2_c0", p_c0[0], C_BASE);
        check("s2_c1", p_c0[1], D_BASE);
        check("s2_b1", pre_b0[1], B_BASE + 32'h4);
        check("s2_len", wb_len[0], 32'd16);
        check("s2_irq", 32'(irq_cnt), 32'h1);

        // edge tiles in M and K, narrow N
        @(negedge clk);
        setup(16'd6, 16'd5, 16'd3);
        run_gemm();
        check("s3_passes", 32'(n_pass), 32'h4);
        check("s3_aval0", p_aval[0], 32'h4);
        check("s3_aval2", p_aval[2], 32'h2);
        check("s3_aval3", p_aval[3], 32'h2);
        check("s3_rm0", p_rm[0], 32'hF);
        check("s3_rm1", p_rm[1], 32'h1);
        check("s3_cm1", p_cm[1], 32'h7);
        check("s3_a2", p_a0[2], A_BASE + 32'h8);
        check("s3_c2", p_c0[2], C_BASE + 32'h4);
        check("s3_c3", p_c0[3], D_BASE + 32'h4);
        check("s3_pre_cnt1", pre_cnt[1], 32'h1);
        check("s3_b3", pre_b0[3], B_BASE + 32'h4);
        check("s3_bload", 32'(bload_cnt), 32'd10);
        check("s3_dwr", 32'(dwr_cnt), 32'd12);
        check("s3_wbs", 32'(n_wb), 32'h2);
        check("s3_len0", wb_len[0], 32'd12);
        check("s3_len1", wb_len[1], 32'd6);
        check("s3_dest1", wb_dest[1], DDR + 32'd16);
        check("s3_src1", wb_src[1], D_BASE + 32'h4);
        csr_read(8'h34, rd);
        check("s3_progress", rd, 32'h0010_0001);

        // K = 0 is rejected
        @(negedge clk);
        setup(16'd4, 16'd0, 16'd4);
        csr_write(8'h00, 32'h1);
        bload_cnt = 0; irq_cnt = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (bus.b_load) bload_cnt++;
            if (bus.irq) irq_cnt++;
        end
        csr_read(8'h04, rd);
        check("s4_err", 32'(rd[2]), 32'h1);
        check("s4_busy", 32'(rd[0]), 32'h0);
        check("s4_bload", 32'(bload_cnt), 32'h0);
        check("s4_irq", 32'(irq_cnt), 32'h0);

        // reset during COMPUTE, then a clean run
        @(negedge clk);
        setup(16'd4, 16'd4, 16'd4);
        bus.core_wb_valid = 1'b1;
        csr_write(8'h00, 32'h1);
        seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.a_valid) begin
                seen = 1'b1;
                break;
            end
        end
        check("s5_reached_compute", 32'(seen), 32'h1);
        rst = 1'b1;
        @(negedge clk);
        check("s5_a_valid", 32'(bus.a_valid), 32'h0);
        check("s5_a_addr", 32'(bus.a_addr), 32'h0);
        check("s5_c_rd_en", 32'(bus.c_rd_en), 32'h0);
        check("s5_d_wr_en", 32'(bus.d_wr_en), 32'h0);
        check("s5_masks", {bus.row_mask, bus.col_mask}, 32'h0);
        check("s5_others", 32'(|{bus.b_load, bus.b_addr, bus.b_index, bus.a_switch, bus.c_addr,
                                 bus.acc_sel, bus.d_addr, bus.axi_start, bus.axi_src_addr,
                                 bus.axi_dest_addr, bus.axi_length, bus.irq}), 32'h0);
        check("s5_status", bus.csr_rd_data, 32'h0);
        rst = 1'b0;
        bus.core_wb_valid = 1'b0;
        csr_read(8'h10, rd);
        check("s5_m_cleared", rd, 32'h0);
        @(negedge clk);
        setup(16'd4, 16'd4, 16'd4);
        run_gemm();
        check("s5_passes", 32'(n_pass), 32'h1);
        check("s5_aval", p_aval[0], 32'h4);
        check("s5_len", wb_len[0], 32'd16);
        check("s5_irq", 32'(irq_cnt), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tiled_gemm_sequencer.md
TILED_GEMM_SEQUENCER -- requirements
Module: tiled_gemm_sequencer

Interface
REQ-001 SHALL have parameter W, default 16, systolic array width; legal values are powers of two, 4..64.
REQ-002 SHALL have parameter ADDR_WIDTH, default 10, on-chip buffer address width.
REQ-003 SHALL have parameter CSR_ADDR_WIDTH, default 8, CSR address width.
REQ-004 clk  in  1  clock; all logic on the rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 csr_addr  in  CSR_ADDR_WIDTH  CSR address.
REQ-007 csr_wr_en  in  1  CSR write strobe.
REQ-008 csr_wr_data  in  32  CSR write data.
REQ-009 csr_rd_data  out  32  combinational CSR read data.
REQ-010 core_wb_valid  in  1  core has one result row ready.
REQ-011 b_load  out  1  B buffer read enable and weight accept.
REQ-012 b_addr  out  ADDR_WIDTH  B buffer address.
REQ-013 b_index  out  clog2(W)  weight row index.
REQ-014 a_valid  out  1  A buffer read enable and input valid.
REQ-015 a_addr  out  ADDR_WIDTH  A buffer address.
REQ-016 a_switch  out  1  weight bank switch pulse.
REQ-017 c_rd_en  out  1  C/partial-sum read enable.
REQ-018 c_addr  out  ADDR_WIDTH  C/partial-sum address.
REQ-019 acc_sel  out  1  0 = C is bias, 1 = C is D scratch (accumulate).
REQ-020 d_wr_en  out  1  D scratch write enable.
REQ-021 d_addr  out  ADDR_WIDTH  D scratch address.
REQ-022 row_mask  out  W  active K rows of the current tile.
REQ-023 col_mask  out  W  active N columns of the current tile.
REQ-024 axi_start  out  1  writeback start pulse.
REQ-025 axi_src_addr  out  ADDR_WIDTH  writeback source (D tile base).
REQ-026 axi_dest_addr  out  32  writeback DDR destination.
REQ-027 axi_length  out  16  writeback element count.
REQ-028 axi_done  in  1  writeback complete.
REQ-029 irq  out  1  one-cycle completion interrupt.

Function
REQ-030 CSR map SHALL be: 0x00 CTRL (bit0 start, write-only), 0x04 STATUS {err, done, busy}, 0x10/14/18 M/K/N [15:0], 0x20/24/28/2C A/B/C/D base addresses, 0x30 DDR base, 0x34 PROGRESS {mt[9:0], nt[9:0], kt[9:0]} (read-only); unmapped addresses SHALL read 0xDEADBEEF.
REQ-031 Tile counts SHALL be MT=ceil(M/W), NT=ceil(N/W), KT=ceil(K/W); loop order SHALL be mt outer, nt middle, kt inner.
REQ-032 FSM states SHALL be IDLE, PRELOAD_B (W cycles), SWITCH (1 cycle), COMPUTE (W cycles), DRAIN, WB_START (1 cycle), WB_WAIT, ADVANCE (1 cycle), DONE (1 cycle).
REQ-033 After DRAIN, the FSM SHALL go to PRELOAD_B if kt<KT-1, else to WB_START; after WB_WAIT it SHALL go to ADVANCE, then to PRELOAD_B for the next (mt,nt), or to DONE after the last tile.
REQ-034 Remainders SHALL be m_rem=min(W, M-mt*W), k_rem and n_rem alike; b_load SHALL assert only for index<k_rem, and a_valid and c_rd_en only for index<m_rem.
REQ-035 row_mask[i] SHALL equal i<k_rem, and col_mask[i] SHALL equal i<n_rem.
REQ-036 Addresses SHALL be: a_addr=A+(mt*KT+kt)*W+i, b_addr=B+(kt*NT+nt)*W+i, d_addr=D+(mt*NT+nt)*W+row, c_addr=(acc_sel?D:C)+(mt*NT+nt)*W+i; all arithmetic SHALL wrap modulo 2^ADDR_WIDTH.
REQ-037 acc_sel SHALL equal (kt!=0); c_rd_en SHALL be coincident with a_valid.
REQ-038 In DRAIN, each core_wb_valid SHALL produce d_wr_en and advance row; DRAIN SHALL end when row==m_rem; core_wb_valid outside COMPUTE/DRAIN SHALL be ignored.
REQ-039 In WB_START, axi_src_addr SHALL be the D tile base, axi_dest_addr=DDR+(mt*NT+nt)*W*W, axi_length=m_rem*n_rem.
REQ-040 Start with M, K or N equal to 0 SHALL set err and leave the FSM in IDLE; start while busy SHALL be ignored.
REQ-041 done SHALL be set when entering DONE and cleared by the next accepted start; irq SHALL pulse in the same cycle that done is set.

Reset
REQ-042 rst SHALL return the FSM to IDLE, clear all counters and CSRs to 0, and drive every output to 0 on the following cycle, including mid-operation.

Configuration
REQ-043 With TILE_PERF_CNT_EN defined, a 32-bit busy-cycle counter SHALL be cleared on start and be readable at 0x40; without it, 0x40 SHALL read 0xDEADBEEF and no counter logic SHALL exist.

Structure
REQ-044 The state enum, CSR offsets, and the 0xDEADBEEF constant SHALL reside in package tile_seq_pkg.
REQ-045 The (mt,nt,kt) loop counters with remainder computation SHALL be sub-module tile_iter.

Verification
REQ-046 W=4, M=K=N=4, start: exactly one tile, acc_sel=0 throughout, axi_length=16, one irq.
REQ-047 W=4, M=4, K=8, N=4: KT=2; acc_sel=1 in the second COMPUTE; c_addr = D base; a_addr base = A+4.
REQ-048 W=4, M=6, K=5, N=3: second mt tile has m_rem=2 (a_valid 2 cycles); second kt tile has row_mask=0001; col_mask=0111.
REQ-049 K=0 start: err=1, busy=0, no b_load or irq.
REQ-050 rst asserted during COMPUTE: next cycle, all outputs 0 and STATUS=0; a new start then runs normally.
